// File: rtl/bus_slave_if.sv
// bus_slave_if: request/acknowledge bundle between a bus master and bus_slave.
// master drives req/we/addr/wdata; slave returns rdata/ack/err and both counters.
interface bus_slave_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 2,
    parameter int CNT_W  = 8
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;
    logic [CNT_W-1:0]  wr_count;
    logic [CNT_W-1:0]  rd_count;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, err, wr_count, rd_count
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, err, wr_count, rd_count
    );
endinterface

// File: rtl/bus_slave.sv
// bus_slave: register-file responder with programmable wait states and
// saturating write/read counters. Ports: clk, rst (sync, active high), bus (slave).
module bus_slave #(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 2,
    parameter int DEPTH       = 3,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    bus_slave_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t state, state_nxt;

    logic [3:0]        wcnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rdata_q;
    logic              ack_q;
    logic              err_q;
    logic [CNT_W-1:0]  wr_q;
    logic [CNT_W-1:0]  rd_q;

    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_map;
    logic              commit;

    // With zero wait states the response edge is also the capture edge,
    // so the live bus fields are used in IDLE and the latched copies after.
    always_comb begin
        c_we    = lat_we;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        if (state == IDLE) begin
            c_we    = bus.we;
            c_addr  = bus.addr;
            c_wdata = bus.wdata;
        end
        c_map = ({1'b0, c_addr} < DEPTH_L);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.req)
                    state_nxt = (WAIT_L != 4'd0) ? WAIT : RESP;
            end
            WAIT: begin
                if (wcnt <= 4'd1)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign commit = (state_nxt == RESP);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt      <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            ack_q <= commit;
            err_q <= commit && !c_map;

            if (state == IDLE && bus.req) begin
                lat_we    <= bus.we;
                lat_addr  <= bus.addr;
                lat_wdata <= bus.wdata;
                wcnt      <= WAIT_L;
            end else if (state == WAIT && wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end

            if (commit) begin
                if (c_we) begin
                    if (c_map) begin
                        mem[c_addr] <= c_wdata;
                        if (wr_q != '1)
                            wr_q <= wr_q + 1'b1;
                    end
                end else begin
                    rdata_q <= c_map ? mem[c_addr] : '0;
                    if (c_map && rd_q != '1)
                        rd_q <= rd_q + 1'b1;
                end
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.wr_count = wr_q;
    assign bus.rd_count = rd_q;

endmodule

// File: doc/bus_slave.md
# bus_slave

Memory-mapped responder at the far end of the processor's master read/write interface. Accepts single write and read requests from `master`, stores data in an internal register file and answers each request with a one-cycle acknowledge after a programmable number of wait states. Keeps saturating counts of completed writes and reads for test-bench scoring. Sits on the processor's local bus, one instance per addressable slave.

## Interface
- `ADDR_W`, 2, address width in bits
- `DATA_W`, 2, data width in bits
- `DEPTH`, 3, number of implemented words, 1..2**ADDR_W; addresses >= DEPTH are unmapped
- `WAIT_CYCLES`, 1, wait states between request capture and acknowledge, 0..15
- `CNT_W`, 8, width of each transaction counter
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  1  request valid; master holds it high with `we`/`addr`/`wdata` stable until `ack`
- `we`  in  1  1 = write, 0 = read
- `addr`  in  ADDR_W  word address
- `wdata`  in  DATA_W  write data
- `rdata`  out  DATA_W  read data, valid while `ack` is high on a read
- `ack`  out  1  one-cycle completion pulse
- `err`  out  1  high together with `ack` when `addr` >= DEPTH
- `wr_count`  out  CNT_W  completed successful writes, saturating
- `rd_count`  out  CNT_W  completed successful reads, saturating

## Operation
- Reset: state IDLE; all register-file words = 0; `rdata` = 0; `ack` = 0; `err` = 0; both counters = 0; wait counter = 0.
- States: IDLE, WAIT, RESP.
- IDLE: if `req` = 1, latch `we`, `addr`, `wdata`; load wait counter with WAIT_CYCLES; go to WAIT if WAIT_CYCLES > 0, else RESP. If `req` = 0, stay.
- WAIT: decrement wait counter each cycle; when it would reach 0, go to RESP. Changes on `req`/`addr`/`wdata` here are ignored (latched copies are used).
- RESP: `ack` = 1 for exactly this cycle; next state IDLE unconditionally.
- Write, mapped address: word[addr] <= latched wdata on the edge entering RESP; `wr_count` increments on the same edge.
- Read, mapped address: `rdata` <= word[addr] on the edge entering RESP; `rd_count` increments on the same edge; `rdata` holds until the next read response or reset.
- Unmapped address (addr >= DEPTH): `err` = 1 with `ack`; write dropped; read returns `rdata` = 0; no counter change.
- Counters saturate at 2**CNT_W-1; no wrap.
- `req` still high in the IDLE cycle after RESP starts a new transaction (master-side back-to-back).
- A write followed by a read to the same address returns the new data (write lands before the next capture).

## Timing
- Request captured at edge N (IDLE, `req` = 1); `ack` high during cycle N+1+WAIT_CYCLES; minimum transaction period WAIT_CYCLES+2 cycles.
- `ack`, `err`, `rdata` are registered outputs; no combinational path from inputs.
- Counters update on the edge that raises `ack`.
- `rst` asserted in any state: next edge returns to reset values; an in-flight write is not committed, no `ack` is produced; `rst` has priority over all other events.

## Test plan
- Reset: hold `rst` 2 cycles -> `ack`=0, `err`=0, `rdata`=0, `wr_count`=0, `rd_count`=0; read addr 0 -> `rdata`=2'b00.
- Write 2'b11 to addr 1, then read addr 1 -> read `ack` with `rdata`=2'b11, `err`=0; `wr_count`=1, `rd_count`=1.
- WAIT_CYCLES=1: `req` captured at edge N -> `ack` high only in cycle N+2; WAIT_CYCLES=0 -> `ack` in cycle N+1; `ack` width exactly 1 cycle in both.
- Unmapped: DEPTH=3, write 2'b10 to addr 3 -> `ack`=1,`err`=1; read addr 3 -> `rdata`=0,`err`=1; `wr_count`,`rd_count` unchanged.
- Saturation: CNT_W=2, 5 writes -> `wr_count`=3 after the 3rd and stays 3.
- Reset mid-transaction: write 2'b01 to addr 2, assert `rst` during WAIT -> no `ack`; subsequent read addr 2 -> `rdata`=2'b00, `wr_count`=0.
